// File: rtl/run_length_detector.sv
// run_length_detector
//   Multi-channel run-length detector. Each channel flags its input once it has
//   been high for RUN_LEN consecutive clock edges and holds the flag until the
//   input has been low for RELEASE_LEN consecutive edges. Each channel also
//   gives a one-cycle detect pulse and a saturating hit counter.
//
//   Ports
//     i_clk          system clock, all logic on posedge
//     i_reset        synchronous, active-high, dominates all other inputs
//     i_enable       0: every channel returns to IDLE on the next edge
//     i_clear_counts synchronous clear of all hit counters
//     i_w            per-channel input, sampled on posedge
//     o_det          channel is DETECTED or RELEASING
//     o_det_pulse    one cycle on entry to DETECTED from IDLE/ARMING
//     o_any_det      OR of o_det
//     o_hit_count    channel i at [i*HIT_W +: HIT_W], saturating

// Per-channel FSM, counters and hit counter. Outputs decode registered state
// only, so there is no combinational path from i_w to any output.
module rld_chan #(
  parameter int RUN_LEN     = 3,
  parameter int RELEASE_LEN = 2,
  parameter int HIT_W       = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_clear_counts,
  input  logic             i_w,
  output logic             o_det,
  output logic             o_det_pulse,
  output logic [HIT_W-1:0] o_hit_count
);
  localparam int RW = $clog2(RUN_LEN + 1);
  localparam int LW = $clog2(RELEASE_LEN + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ARMING    = 2'd1;
  localparam logic [1:0] DETECTED  = 2'd2;
  localparam logic [1:0] RELEASING = 2'd3;

  logic [1:0]       r_state, w_state_nx;
  logic [RW-1:0]    r_run, w_run_nx, w_run_inc;
  logic [LW-1:0]    r_rel, w_rel_nx, w_rel_inc;
  logic             r_pulse, w_hit_inc;
  logic [HIT_W-1:0] r_hit;

  assign w_run_inc = r_run + 1'b1;
  assign w_rel_inc = r_rel + 1'b1;

  always_comb begin
    w_state_nx = r_state;
    w_run_nx   = r_run;
    w_rel_nx   = r_rel;
    w_hit_inc  = 1'b0;   // doubles as "fresh detect" this edge
    if (!i_enable) begin
      w_state_nx = IDLE;
      w_run_nx   = '0;
      w_rel_nx   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_w) begin
            if (RUN_LEN == 1) begin
              w_state_nx = DETECTED;
              w_hit_inc  = 1'b1;
            end else begin
              w_state_nx = ARMING;
              w_run_nx   = RW'(1);
            end
          end
        end
        ARMING: begin
          if (!i_w) begin
            w_state_nx = IDLE;
            w_run_nx   = '0;
          end else if (w_run_inc == RW'(RUN_LEN)) begin
            w_state_nx = DETECTED;
            w_run_nx   = '0;
            w_hit_inc  = 1'b1;
          end else begin
            w_run_nx   = w_run_inc;
          end
        end
        DETECTED: begin
          if (!i_w) begin
            if (RELEASE_LEN == 1) begin
              w_state_nx = IDLE;
            end else begin
              w_state_nx = RELEASING;
              w_rel_nx   = LW'(1);
            end
          end
        end
        RELEASING: begin
          // Returning high here resumes detection silently: no pulse, no count.
          if (i_w) begin
            w_state_nx = DETECTED;
            w_rel_nx   = '0;
          end else if (w_rel_inc == LW'(RELEASE_LEN)) begin
            w_state_nx = IDLE;
            w_rel_nx   = '0;
          end else begin
            w_rel_nx   = w_rel_inc;
          end
        end
        default: begin
          w_state_nx = IDLE;
          w_run_nx   = '0;
          w_rel_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_run   <= '0;
      r_rel   <= '0;
      r_pulse <= 1'b0;
      r_hit   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_run   <= w_run_nx;
      r_rel   <= w_rel_nx;
      r_pulse <= w_hit_inc;
      // Clear wins over a coincident increment; counter saturates at all-ones.
      if (i_clear_counts)
        r_hit <= '0;
      else if (w_hit_inc && (r_hit != {HIT_W{1'b1}}))
        r_hit <= r_hit + 1'b1;
    end
  end

  assign o_det       = (r_state == DETECTED) || (r_state == RELEASING);
  assign o_det_pulse = r_pulse;
  assign o_hit_count = r_hit;
endmodule

module run_length_detector #(
  parameter int CHANNELS    = 4,
  parameter int RUN_LEN     = 3,
  parameter int RELEASE_LEN = 2,
  parameter int HIT_W       = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_clear_counts,
  input  logic [CHANNELS-1:0]       i_w,
  output logic [CHANNELS-1:0]       o_det,
  output logic [CHANNELS-1:0]       o_det_pulse,
  output logic                      o_any_det,
  output logic [CHANNELS*HIT_W-1:0] o_hit_count
);
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    rld_chan #(
      .RUN_LEN    (RUN_LEN),
      .RELEASE_LEN(RELEASE_LEN),
      .HIT_W      (HIT_W)
    ) u_chan (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_enable      (i_enable),
      .i_clear_counts(i_clear_counts),
      .i_w           (i_w[g]),
      .o_det         (o_det[g]),
      .o_det_pulse   (o_det_pulse[g]),
      .o_hit_count   (o_hit_count[g*HIT_W +: HIT_W])
    );
  end

  // o_det is decoded from registered state, so this stays free of i_w paths.
  assign o_any_det = |o_det;
endmodule

// File: tb/tb_run_length_detector.sv
module tb_run_length_detector;
  logic        clk = 1'b0;
  logic        reset, enable, clear_counts;
  logic [3:0]  w;
  logic [3:0]  da_det, da_pulse, db_det, db_pulse;
  logic        da_any, db_any;
  logic [15:0] da_hit;
  logic [7:0]  db_hit;

  always #5 clk = ~clk;

  // a: default parameters; b: RUN_LEN=2, RELEASE_LEN=1, HIT_W=2
  run_length_detector dut_a (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_clear_counts(clear_counts),
    .i_w(w), .o_det(da_det), .o_det_pulse(da_pulse), .o_any_det(da_any),
    .o_hit_count(da_hit));

  run_length_detector #(.CHANNELS(4), .RUN_LEN(2), .RELEASE_LEN(1), .HIT_W(2)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_clear_counts(clear_counts),
    .i_w(w), .o_det(db_det), .o_det_pulse(db_pulse), .o_any_det(db_any),
    .o_hit_count(db_hit));

  int checks = 0;
  int errors = 0;

  // Reference model: streak lengths of highs/lows; detection is a hysteresis on them.
  int hs [2][4];
  int ls [2][4];
  int hit[2][4];
  bit mdet[2][4];
  bit mpul[2][4];

  function automatic int run_of(input int c);  return (c == 0) ? 3 : 2;  endfunction
  function automatic int rel_of(input int c);  return (c == 0) ? 2 : 1;  endfunction
  function automatic int hmax_of(input int c); return (c == 0) ? 15 : 3; endfunction

  task automatic model_update(input logic r, input logic en, input logic clr, input logic [3:0] wv);
    for (int c = 0; c < 2; c++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (r) begin
          hs[c][ch] = 0; ls[c][ch] = 0; hit[c][ch] = 0;
          mdet[c][ch] = 0; mpul[c][ch] = 0;
        end else begin
          if (!en) begin
            hs[c][ch] = 0; ls[c][ch] = 0; mdet[c][ch] = 0; mpul[c][ch] = 0;
          end else begin
            bit nd;
            if (wv[ch]) begin hs[c][ch]++; ls[c][ch] = 0; end
            else        begin ls[c][ch]++; hs[c][ch] = 0; end
            nd = mdet[c][ch] ? (ls[c][ch] < rel_of(c)) : (hs[c][ch] >= run_of(c));
            mpul[c][ch] = nd && !mdet[c][ch];
            mdet[c][ch] = nd;
          end
          if (clr) hit[c][ch] = 0;
          else if (mpul[c][ch] && hit[c][ch] < hmax_of(c)) hit[c][ch]++;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [3:0]  ed_a, ep_a, ed_b, ep_b;
    logic [15:0] eh_a;
    logic [7:0]  eh_b;
    for (int ch = 0; ch < 4; ch++) begin
      ed_a[ch] = mdet[0][ch]; ep_a[ch] = mpul[0][ch];
      ed_b[ch] = mdet[1][ch]; ep_b[ch] = mpul[1][ch];
      eh_a[ch*4 +: 4] = 4'(hit[0][ch]);
      eh_b[ch*2 +: 2] = 2'(hit[1][ch]);
    end
    chk("a_det",   32'(da_det),   32'(ed_a));
    chk("a_pulse", 32'(da_pulse), 32'(ep_a));
    chk("a_any",   32'(da_any),   32'(|ed_a));
    chk("a_hit",   32'(da_hit),   32'(eh_a));
    chk("b_det",   32'(db_det),   32'(ed_b));
    chk("b_pulse", 32'(db_pulse), 32'(ep_b));
    chk("b_any",   32'(db_any),   32'(|ed_b));
    chk("b_hit",   32'(db_hit),   32'(eh_b));
  endtask

  task automatic step(input logic r, input logic en, input logic clr, input logic [3:0] wv);
    reset = r; enable = en; clear_counts = clr; w = wv;
    @(posedge clk);
    model_update(r, en, clr, wv);
    #1;
    check_all();
  endtask

  typedef struct {
    logic       r;
    logic       en;
    logic [3:0] wv;
    logic [3:0] det;
    logic [3:0] pulse;
    logic [3:0] hit0;
  } vec_t;

  vec_t tbl[18];

  initial begin
    reset = 1'b1; enable = 1'b1; clear_counts = 1'b0; w = 4'h0;

    // Directed vectors for the default-parameter instance.
    tbl[0]  = '{1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'd0};
    tbl[1]  = '{1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'd0};
    tbl[2]  = '{1'b0, 1'b1, 4'h3, 4'h0, 4'h0, 4'd0};
    tbl[3]  = '{1'b0, 1'b1, 4'h3, 4'h0, 4'h0, 4'd0};
    tbl[4]  = '{1'b0, 1'b1, 4'h3, 4'h3, 4'h3, 4'd1};
    tbl[5]  = '{1'b0, 1'b1, 4'h3, 4'h3, 4'h0, 4'd1};
    tbl[6]  = '{1'b0, 1'b1, 4'h1, 4'h3, 4'h0, 4'd1};
    tbl[7]  = '{1'b0, 1'b1, 4'h3, 4'h3, 4'h0, 4'd1};
    tbl[8]  = '{1'b0, 1'b1, 4'h1, 4'h3, 4'h0, 4'd1};
    tbl[9]  = '{1'b0, 1'b1, 4'h1, 4'h1, 4'h0, 4'd1};
    tbl[10] = '{1'b0, 1'b1, 4'h0, 4'h1, 4'h0, 4'd1};
    tbl[11] = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'd1};
    tbl[12] = '{1'b0, 1'b1, 4'h1, 4'h0, 4'h0, 4'd1};
    tbl[13] = '{1'b0, 1'b1, 4'h1, 4'h0, 4'h0, 4'd1};
    tbl[14] = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'd1};
    tbl[15] = '{1'b0, 1'b1, 4'h1, 4'h0, 4'h0, 4'd1};
    tbl[16] = '{1'b0, 1'b1, 4'h1, 4'h0, 4'h0, 4'd1};
    tbl[17] = '{1'b0, 1'b1, 4'h1, 4'h1, 4'h1, 4'd2};

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].r, tbl[i].en, 1'b0, tbl[i].wv);
      chk($sformatf("tbl%0d_det", i),   32'(da_det),      32'(tbl[i].det));
      chk($sformatf("tbl%0d_pulse", i), 32'(da_pulse),    32'(tbl[i].pulse));
      chk($sformatf("tbl%0d_hit0", i),  32'(da_hit[3:0]), 32'(tbl[i].hit0));
    end

    // Short run/release instance: 1,1,0 on ch0.
    step(1'b1, 1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b1, 1'b0, 4'h1); chk("b_rl2_e1", 32'(db_det[0]), 32'd0);
    step(1'b0, 1'b1, 1'b0, 4'h1); chk("b_rl2_e2", 32'(db_det[0]), 32'd1);
    step(1'b0, 1'b1, 1'b0, 4'h0); chk("b_rl2_e3", 32'(db_det[0]), 32'd0);

    // Hit counter saturation and clear-vs-increment on ch2 of the 2-bit instance.
    step(1'b1, 1'b1, 1'b0, 4'h0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 1'b0, 4'h4);
      step(1'b0, 1'b1, 1'b0, 4'h4);
      step(1'b0, 1'b1, 1'b0, 4'h0);
    end
    chk("b_hit2_sat", 32'(db_hit[5:4]), 32'd3);
    step(1'b0, 1'b1, 1'b0, 4'h4);
    step(1'b0, 1'b1, 1'b1, 4'h4);
    chk("b_clr_pulse", 32'(db_pulse[2]), 32'd1);
    chk("b_clr_hit",   32'(db_hit[5:4]), 32'd0);

    // Reset and enable drop while ch3 is mid-run / detected.
    step(1'b1, 1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b1, 1'b0, 4'h8);
    step(1'b0, 1'b1, 1'b0, 4'h8);
    step(1'b1, 1'b1, 1'b0, 4'h8);
    chk("a_rst_det3",   32'(da_det[3]),   32'd0);
    chk("a_rst_pulse3", 32'(da_pulse[3]), 32'd0);
    step(1'b0, 1'b1, 1'b0, 4'h8);
    step(1'b0, 1'b1, 1'b0, 4'h8);
    chk("a_rerun_e2", 32'(da_det[3]), 32'd0);
    step(1'b0, 1'b1, 1'b0, 4'h8);
    chk("a_rerun_e3", 32'(da_det[3]), 32'd1);
    step(1'b0, 1'b0, 1'b0, 4'h8);
    chk("a_dis_det3",   32'(da_det[3]),      32'd0);
    chk("a_dis_pulse3", 32'(da_pulse[3]),    32'd0);
    chk("a_dis_hit3",   32'(da_hit[15:12]),  32'd1);
    step(1'b0, 1'b1, 1'b0, 4'h8);
    step(1'b0, 1'b1, 1'b0, 4'h8);
    chk("a_en_e2", 32'(da_det[3]), 32'd0);
    step(1'b0, 1'b1, 1'b0, 4'h8);
    chk("a_en_e3",       32'(da_det[3]),     32'd1);
    chk("a_en_pulse3",   32'(da_pulse[3]),   32'd1);
    chk("a_en_hit3",     32'(da_hit[15:12]), 32'd2);

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic r, en, clr;
      logic [3:0] wv;
      r   = ($urandom_range(0, 99) == 0);
      en  = ($urandom_range(0, 15) != 0);
      clr = ($urandom_range(0, 31) == 0);
      // Bias towards long runs so detect/release paths get exercised.
      wv  = (n % 8 < 5) ? 4'($urandom | $urandom) : 4'($urandom & $urandom);
      step(r, en, clr, wv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
